// File: rtl/controlador_display_pkg.sv
// ---------------------------------------------------------------------------
// controlador_display_pkg
// Shared definitions for the display sequencer: FSM state encodings, the
// mux select values understood by the display manager, and a helper that
// maps a state to the view it shows.
// ---------------------------------------------------------------------------
package controlador_display_pkg;

  // State encodings are visible on the debug port, so their values are fixed.
  typedef enum logic [2:0] {
    DESLIGADO   = 3'd0,
    ALT_ANDAR   = 3'd1,
    ALT_PESSOAS = 3'd2,
    EVT_ANDAR   = 3'd3,
    EVT_PESSOAS = 3'd4,
    ALERTA      = 3'd5
  } estado_t;

  localparam logic SEL_ANDAR   = 1'b0;
  localparam logic SEL_PESSOAS = 1'b1;

  // The alarm blinks the occupancy view, so ALERTA selects occupancy too.
  function automatic logic selecaoVista(input estado_t estado);
    case (estado)
      ALT_PESSOAS, EVT_PESSOAS, ALERTA: selecaoVista = SEL_PESSOAS;
      default:                          selecaoVista = SEL_ANDAR;
    endcase
  endfunction

endpackage

// File: rtl/controlador_display_temporizador.sv
// ---------------------------------------------------------------------------
// temporizador
// Clearable up-counter that flags the last cycle of a programmable interval.
// The owner clears it on expiry or whenever the interval must restart, so the
// count never runs past limite-1 and never wraps.
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_limpar   synchronous clear; count is 0 in the cycle after it is sampled
//   i_limite   interval length in cycles (>= 1)
//   o_expira   high while the count equals i_limite-1
// ---------------------------------------------------------------------------
module temporizador #(
  parameter int LARGURA_CONT = 27
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_limpar,
  input  logic [LARGURA_CONT-1:0] i_limite,
  output logic                    o_expira
);

  logic [LARGURA_CONT-1:0] r_contagem;

  // Counts cycles since the last clear; a clear always wins over the increment.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_contagem <= '0;
    end else if (i_limpar) begin
      r_contagem <= '0;
    end else begin
      r_contagem <= r_contagem + LARGURA_CONT'(1);
    end
  end

  assign o_expira = (r_contagem == (i_limite - LARGURA_CONT'(1)));

endmodule

// File: rtl/controlador_display.sv
// ---------------------------------------------------------------------------
// controlador_display
// Sequencer for the 7-segment display path. Alternates between floor and
// occupancy views at a fixed dwell, gives a longer hold to whichever value
// just changed, blinks the occupancy view while overload is active and
// blanks the display when disabled.
//
// Ports:
//   i_clock         system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_habilitar     display enable; 0 blanks the display
//   i_andar         current floor code
//   i_pessoas       occupancy code {A,B}
//   i_sobrecarga    overload alarm level
//   o_controle_mux  0 = floor view, 1 = occupancy view (registered)
//   o_apagar        1 = all segments off (registered)
//   o_estado        current FSM state encoding, for debug
// ---------------------------------------------------------------------------
module controlador_display
  import controlador_display_pkg::*;
#(
  parameter int CICLOS_TROCA  = 50_000_000,
  parameter int CICLOS_EVENTO = 100_000_000,
  parameter int CICLOS_PISCA  = 12_500_000,
  parameter int LARGURA_CONT  = 27
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_habilitar,
  input  logic [1:0] i_andar,
  input  logic [1:0] i_pessoas,
  input  logic       i_sobrecarga,
  output logic       o_controle_mux,
  output logic       o_apagar,
  output logic [2:0] o_estado
);

  localparam logic [LARGURA_CONT-1:0] LIM_TROCA  = LARGURA_CONT'(CICLOS_TROCA);
  localparam logic [LARGURA_CONT-1:0] LIM_EVENTO = LARGURA_CONT'(CICLOS_EVENTO);
  localparam logic [LARGURA_CONT-1:0] LIM_PISCA  = LARGURA_CONT'(CICLOS_PISCA);

  estado_t r_estado;
  estado_t w_proxEstado;
  logic    r_controle_mux;
  logic    r_apagar;
  logic [1:0] r_andarAnt;
  logic [1:0] r_pessoasAnt;

  logic w_mudAndar;
  logic w_mudPessoas;
  logic w_reiniciaEvento;
  logic w_limparEstado;
  logic w_limparPisca;
  logic w_expiraEstado;
  logic w_expiraPisca;
  logic [LARGURA_CONT-1:0] w_limiteEstado;

  // Changes are compared against last cycle's value and are never latched.
  assign w_mudAndar   = (i_andar   != r_andarAnt);
  assign w_mudPessoas = (i_pessoas != r_pessoasAnt);

  // Event-hold states use the longer interval; other states use the dwell.
  assign w_limiteEstado = ((r_estado == EVT_ANDAR) || (r_estado == EVT_PESSOAS))
                          ? LIM_EVENTO : LIM_TROCA;

  // Next-state selection in priority order: disable, alarm, floor change,
  // occupancy change, timer expiry. Leaving DESLIGADO always lands in
  // ALT_ANDAR so re-enable starts from a known view; leaving ALERTA does the
  // same and ignores any change seen while the alarm was up.
  always_comb begin
    w_proxEstado     = r_estado;
    w_reiniciaEvento = 1'b0;
    if (!i_habilitar) begin
      w_proxEstado = DESLIGADO;
    end else if (r_estado == DESLIGADO) begin
      w_proxEstado = ALT_ANDAR;
    end else if (i_sobrecarga) begin
      w_proxEstado = ALERTA;
    end else if (r_estado == ALERTA) begin
      w_proxEstado = ALT_ANDAR;
    end else if (w_mudAndar) begin
      w_proxEstado     = EVT_ANDAR;
      w_reiniciaEvento = 1'b1;
    end else if (w_mudPessoas && (r_estado != EVT_ANDAR)) begin
      w_proxEstado     = EVT_PESSOAS;
      w_reiniciaEvento = 1'b1;
    end else if (w_expiraEstado) begin
      case (r_estado)
        ALT_ANDAR:   w_proxEstado = ALT_PESSOAS;
        ALT_PESSOAS: w_proxEstado = ALT_ANDAR;
        EVT_ANDAR:   w_proxEstado = ALT_PESSOAS;
        EVT_PESSOAS: w_proxEstado = ALT_ANDAR;
        default:     w_proxEstado = r_estado;
      endcase
    end
  end

  // The state timer restarts on every entry and event restart, and is held
  // at zero in the states that do not use it so it can never overflow.
  assign w_limparEstado = (w_proxEstado != r_estado) || w_reiniciaEvento ||
                          (w_proxEstado == DESLIGADO) || (w_proxEstado == ALERTA);

  // The blink timer only runs while staying in ALERTA; each expiry starts
  // the next half-period.
  assign w_limparPisca = (r_estado != ALERTA) || (w_proxEstado != ALERTA) ||
                         w_expiraPisca;

  temporizador #(
    .LARGURA_CONT (LARGURA_CONT)
  ) u_timerEstado (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_limpar  (w_limparEstado),
    .i_limite  (w_limiteEstado),
    .o_expira  (w_expiraEstado)
  );

  temporizador #(
    .LARGURA_CONT (LARGURA_CONT)
  ) u_timerPisca (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_limpar  (w_limparPisca),
    .i_limite  (LIM_PISCA),
    .o_expira  (w_expiraPisca)
  );

  // State, history and outputs are all registered from the next state so
  // the outputs always match the state they belong to. Blanking starts low
  // on ALERTA entry and toggles at each blink expiry while the alarm holds.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_estado       <= DESLIGADO;
      r_controle_mux <= SEL_ANDAR;
      r_apagar       <= 1'b1;
      r_andarAnt     <= 2'b00;
      r_pessoasAnt   <= 2'b00;
    end else begin
      r_estado       <= w_proxEstado;
      r_controle_mux <= selecaoVista(w_proxEstado);
      r_andarAnt     <= i_andar;
      r_pessoasAnt   <= i_pessoas;
      case (w_proxEstado)
        DESLIGADO: r_apagar <= 1'b1;
        ALERTA:    r_apagar <= (r_estado == ALERTA) ? (r_apagar ^ w_expiraPisca) : 1'b0;
        default:   r_apagar <= 1'b0;
      endcase
    end
  end

  assign o_controle_mux = r_controle_mux;
  assign o_apagar       = r_apagar;
  assign o_estado       = r_estado;

endmodule

// File: tb/tb_controlador_display.sv
// ---------------------------------------------------------------------------
// tb_controlador_display
// Directed bench for the display sequencer with short intervals
// (dwell 8, event hold 5, blink half-period 2). Outputs are observed as one
// vector {estado, controle_mux, apagar}.
// ---------------------------------------------------------------------------
module tb_controlador_display;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       habilitar;
  logic [1:0] andar;
  logic [1:0] pessoas;
  logic       sobrecarga;
  logic       controle_mux;
  logic       apagar;
  logic [2:0] estado;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;

  // Expected {estado, controle_mux, apagar} per state.
  localparam logic [4:0] E_DESL = 5'b000_0_1;
  localparam logic [4:0] E_ALTA = 5'b001_0_0;
  localparam logic [4:0] E_ALTP = 5'b010_1_0;
  localparam logic [4:0] E_EVTA = 5'b011_0_0;
  localparam logic [4:0] E_EVTP = 5'b100_1_0;
  localparam logic [4:0] E_ALR0 = 5'b101_1_0;
  localparam logic [4:0] E_ALR1 = 5'b101_1_1;

  controlador_display #(
    .CICLOS_TROCA  (8),
    .CICLOS_EVENTO (5),
    .CICLOS_PISCA  (2),
    .LARGURA_CONT  (27)
  ) dut (
    .i_clock        (clock),
    .i_reset_n      (reset_n),
    .i_habilitar    (habilitar),
    .i_andar        (andar),
    .i_pessoas      (pessoas),
    .i_sobrecarga   (sobrecarga),
    .o_controle_mux (controle_mux),
    .o_apagar       (apagar),
    .o_estado       (estado)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  assign obs = {estado, controle_mux, apagar};

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    habilitar  = 1'b0;
    andar      = 2'd0;
    pessoas    = 2'd0;
    sobrecarga = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%b expected=%b", obs, E_DESL);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL stays_disabled got=%b expected=%b", obs, E_DESL);
    end
  endtask

  // Static inputs: one cycle in DESLIGADO, then 8 floor / 8 occupancy.
  task automatic test_alternancia();
    logic [4:0] esperado;
    habilitar = 1'b1;
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL before_enable_edge got=%b expected=%b", obs, E_DESL);
    end
    for (int i = 0; i < 32; i++) begin
      tick();
      esperado = (((i / 8) % 2) == 0) ? E_ALTA : E_ALTP;
      checks++;
      if (obs !== esperado) begin
        errors++;
        $display("[TB] FAIL alternation cycle=%0d got=%b expected=%b", i, obs, esperado);
      end
    end
  endtask

  // Floor change during ALT_PESSOAS: floor view for exactly 5 cycles.
  task automatic test_evento_andar();
    repeat (9) tick();
    checks++;
    if (obs !== E_ALTP) begin
      errors++;
      $display("[TB] FAIL pre_floor_event got=%b expected=%b", obs, E_ALTP);
    end
    andar = 2'd2;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (obs !== E_EVTA) begin
        errors++;
        $display("[TB] FAIL floor_event_hold cycle=%0d got=%b expected=%b", j, obs, E_EVTA);
      end
    end
    tick();
    checks++;
    if (obs !== E_ALTP) begin
      errors++;
      $display("[TB] FAIL floor_event_end got=%b expected=%b", obs, E_ALTP);
    end
  endtask

  // Simultaneous change favours floor; occupancy change during it is dropped.
  task automatic test_simultaneo();
    andar   = 2'd1;
    pessoas = 2'd3;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++;
      if (obs !== E_EVTA) begin
        errors++;
        $display("[TB] FAIL simultaneous_floor_wins cycle=%0d got=%b expected=%b", j, obs, E_EVTA);
      end
    end
    pessoas = 2'd1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (obs !== E_EVTA) begin
        errors++;
        $display("[TB] FAIL occupancy_ignored cycle=%0d got=%b expected=%b", j, obs, E_EVTA);
      end
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++;
      if (obs !== E_ALTP) begin
        errors++;
        $display("[TB] FAIL simultaneous_end cycle=%0d got=%b expected=%b", j, obs, E_ALTP);
      end
    end
  endtask

  // Ten cycles of overload: blink 0,0,1,1,... then back to ALT_ANDAR.
  task automatic test_alerta();
    logic [4:0] esperado;
    sobrecarga = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      esperado = (((i / 2) % 2) == 0) ? E_ALR0 : E_ALR1;
      checks++;
      if (obs !== esperado) begin
        errors++;
        $display("[TB] FAIL alarm_blink cycle=%0d got=%b expected=%b", i, obs, esperado);
      end
    end
    sobrecarga = 1'b0;
    tick();
    checks++;
    if (obs !== E_ALTA) begin
      errors++;
      $display("[TB] FAIL alarm_release got=%b expected=%b", obs, E_ALTA);
    end
  endtask

  // Event on the expiry cycle wins; a second floor change restarts the hold.
  task automatic test_evento_expira();
    repeat (7) tick();
    checks++;
    if (obs !== E_ALTA) begin
      errors++;
      $display("[TB] FAIL last_dwell_cycle got=%b expected=%b", obs, E_ALTA);
    end
    andar = 2'd0;
    tick();
    checks++;
    if (obs !== E_EVTA) begin
      errors++;
      $display("[TB] FAIL event_beats_expiry got=%b expected=%b", obs, E_EVTA);
    end
    tick();
    tick();
    andar = 2'd2;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (obs !== E_EVTA) begin
        errors++;
        $display("[TB] FAIL floor_restart_hold cycle=%0d got=%b expected=%b", j, obs, E_EVTA);
      end
    end
    tick();
    checks++;
    if (obs !== E_ALTP) begin
      errors++;
      $display("[TB] FAIL floor_restart_end got=%b expected=%b", obs, E_ALTP);
    end
  endtask

  // Occupancy change from ALT_PESSOAS, restarted by a second change.
  task automatic test_evento_pessoas();
    pessoas = 2'd2;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (obs !== E_EVTP) begin
        errors++;
        $display("[TB] FAIL occupancy_event cycle=%0d got=%b expected=%b", j, obs, E_EVTP);
      end
    end
    pessoas = 2'd0;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (obs !== E_EVTP) begin
        errors++;
        $display("[TB] FAIL occupancy_restart cycle=%0d got=%b expected=%b", j, obs, E_EVTP);
      end
    end
    tick();
    checks++;
    if (obs !== E_ALTA) begin
      errors++;
      $display("[TB] FAIL occupancy_event_end got=%b expected=%b", obs, E_ALTA);
    end
  endtask

  // Disable mid-event, change occupancy while off, re-enable with fresh timer.
  task automatic test_desabilitar();
    andar = 2'd3;
    tick();
    checks++;
    if (obs !== E_EVTA) begin
      errors++;
      $display("[TB] FAIL event_before_disable got=%b expected=%b", obs, E_EVTA);
    end
    tick();
    habilitar = 1'b0;
    tick();
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL disable_blanks got=%b expected=%b", obs, E_DESL);
    end
    pessoas = 2'd1;
    tick();
    tick();
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL disabled_hold got=%b expected=%b", obs, E_DESL);
    end
    habilitar = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if (obs !== E_ALTA) begin
        errors++;
        $display("[TB] FAIL reenable_floor cycle=%0d got=%b expected=%b", j, obs, E_ALTA);
      end
    end
    tick();
    checks++;
    if (obs !== E_ALTP) begin
      errors++;
      $display("[TB] FAIL reenable_fresh_timer got=%b expected=%b", obs, E_ALTP);
    end
  endtask

  // Reset dropped between edges while in ALERTA takes effect immediately.
  task automatic test_reset_assincrono();
    sobrecarga = 1'b1;
    tick();
    checks++;
    if (obs !== E_ALR0) begin
      errors++;
      $display("[TB] FAIL alarm_entry got=%b expected=%b", obs, E_ALR0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL async_reset got=%b expected=%b", obs, E_DESL);
    end
    tick();
    checks++;
    if (obs !== E_DESL) begin
      errors++;
      $display("[TB] FAIL reset_held got=%b expected=%b", obs, E_DESL);
    end
    sobrecarga = 1'b0;
    reset_n    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alternancia();
    test_evento_andar();
    test_simultaneo();
    test_alerta();
    test_evento_expira();
    test_evento_pessoas();
    test_desabilitar();
    test_reset_assincrono();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
